// File: rtl/music_pkg.sv
// Shared types and default widths for the song sequencer slice.
// rom_data packs {note, duration}: note in the MSBs, duration in the LSBs.
package music_pkg;

  localparam int SONG_W_DEF = 2;
  localparam int ADDR_W_DEF = 5;
  localparam int NOTE_W_DEF = 6;
  localparam int DUR_W_DEF  = 6;

  localparam int ROM_W_DEF    = NOTE_W_DEF + DUR_W_DEF;
  localparam int DUR_LSB_DEF  = 0;
  localparam int NOTE_LSB_DEF = DUR_W_DEF;

  typedef enum logic [2:0] {
    ST_PAUSED    = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ROM_WAIT  = 3'd2,
    ST_CHECK     = 3'd3,
    ST_WAIT_DONE = 3'd4
  } seq_state_e;

endpackage

// File: rtl/song_sequencer_if.sv
// Sequencer-side bundle: buttons, song ROM port and note player control.
// master is the sequencer; slave is the surrounding buttons/ROM/player.
interface song_sequencer_if
  import music_pkg::*;
#(
  parameter int SONG_W = SONG_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W  = DUR_W_DEF
);

  logic                      play_button;
  logic                      next_button;
  logic                      note_done;
  logic [NOTE_W+DUR_W-1:0]   rom_data;
  logic [SONG_W+ADDR_W-1:0]  rom_addr;
  logic                      play;
  logic                      new_note;
  logic [NOTE_W-1:0]         note;
  logic [DUR_W-1:0]          duration;
  logic [SONG_W-1:0]         song;
  logic                      song_done;
  logic                      reset_player;

  modport master (
    input  play_button, next_button, note_done, rom_data,
    output rom_addr, play, new_note, note, duration, song, song_done, reset_player
  );

  modport slave (
    output play_button, next_button, note_done, rom_data,
    input  rom_addr, play, new_note, note, duration, song, song_done, reset_player
  );

endinterface

// File: rtl/song_addr_counter.sv
// Song index and note address within the song; next_song also rewinds the note.
module song_addr_counter #(
  parameter int SONG_W = 2,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_note_i,
  input  logic              next_song_i,
  input  logic              clr_note_i,
  output logic [SONG_W-1:0] song_o,
  output logic [ADDR_W-1:0] note_addr_o,
  output logic              last_note_o
);

  logic [SONG_W-1:0] song_q;
  logic [ADDR_W-1:0] note_addr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      song_q      <= '0;
      note_addr_q <= '0;
    end else if (next_song_i) begin
      song_q      <= song_q + 1'b1;
      note_addr_q <= '0;
    end else if (clr_note_i) begin
      note_addr_q <= '0;
    end else if (inc_note_i) begin
      note_addr_q <= note_addr_q + 1'b1;
    end
  end

  assign song_o      = song_q;
  assign note_addr_o = note_addr_q;
  assign last_note_o = &note_addr_q;

endmodule

// File: rtl/song_sequencer.sv
// Walks the note player through the current song, one ROM entry per note.
// next_button overrides everything; a zero duration or the last address ends the song.
module song_sequencer
  import music_pkg::*;
#(
  parameter int SONG_W = SONG_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W  = DUR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  song_sequencer_if.master bus
);

  seq_state_e        state_q;
  logic              play_q;
  logic              new_note_q;
  logic              song_done_q;
  logic              reset_player_q;
  logic [NOTE_W-1:0] note_q;
  logic [DUR_W-1:0]  duration_q;

  logic [SONG_W-1:0] song;
  logic [ADDR_W-1:0] note_addr;
  logic              last_note;
  logic              dur_zero;
  logic              inc_note;
  logic              clr_note;

  assign dur_zero = (bus.rom_data[DUR_W-1:0] == '0);

  assign inc_note = !bus.next_button && (state_q == ST_WAIT_DONE) && bus.note_done && !last_note;
  assign clr_note = !bus.next_button &&
                    (((state_q == ST_CHECK) && dur_zero) ||
                     ((state_q == ST_WAIT_DONE) && bus.note_done && last_note));

  song_addr_counter #(
    .SONG_W(SONG_W),
    .ADDR_W(ADDR_W)
  ) u_addr (
    .clk         (clk),
    .reset       (reset),
    .inc_note_i  (inc_note),
    .next_song_i (bus.next_button),
    .clr_note_i  (clr_note),
    .song_o      (song),
    .note_addr_o (note_addr),
    .last_note_o (last_note)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_PAUSED;
      play_q         <= 1'b0;
      new_note_q     <= 1'b0;
      song_done_q    <= 1'b0;
      reset_player_q <= 1'b0;
      note_q         <= '0;
      duration_q     <= '0;
    end else begin
      new_note_q     <= 1'b0;
      song_done_q    <= 1'b0;
      reset_player_q <= 1'b0;
      if (bus.next_button) begin
        state_q        <= ST_PAUSED;
        play_q         <= 1'b0;
        reset_player_q <= 1'b1;
      end else begin
        case (state_q)
          ST_PAUSED: begin
            if (bus.play_button) begin
              state_q <= ST_FETCH;
              play_q  <= 1'b1;
            end
          end
          ST_FETCH, ST_ROM_WAIT: begin
            if (bus.play_button) begin
              state_q <= ST_PAUSED;
              play_q  <= 1'b0;
            end else begin
              state_q <= (state_q == ST_FETCH) ? ST_ROM_WAIT : ST_CHECK;
            end
          end
          // End-of-song wins over a pause arriving in the same cycle.
          ST_CHECK: begin
            if (dur_zero) begin
              state_q     <= ST_PAUSED;
              play_q      <= 1'b0;
              song_done_q <= 1'b1;
            end else if (bus.play_button) begin
              state_q <= ST_PAUSED;
              play_q  <= 1'b0;
            end else begin
              state_q    <= ST_WAIT_DONE;
              note_q     <= bus.rom_data[DUR_W +: NOTE_W];
              duration_q <= bus.rom_data[DUR_W-1:0];
              new_note_q <= 1'b1;
            end
          end
          ST_WAIT_DONE: begin
            if (bus.note_done && last_note) begin
              state_q     <= ST_PAUSED;
              play_q      <= 1'b0;
              song_done_q <= 1'b1;
            end else if (bus.play_button) begin
              state_q <= ST_PAUSED;
              play_q  <= 1'b0;
            end else if (bus.note_done) begin
              state_q <= ST_FETCH;
            end
          end
          default: begin
            state_q <= ST_PAUSED;
            play_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rom_addr     = {song, note_addr};
  assign bus.play         = play_q;
  assign bus.new_note     = new_note_q;
  assign bus.note         = note_q;
  assign bus.duration     = duration_q;
  assign bus.song         = song;
  assign bus.song_done    = song_done_q;
  assign bus.reset_player = reset_player_q;

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Sequences the note player through a song stored in the song ROM.
- Handles play/pause and next-song button pulses, and fetches notes in order. Hands each note to the note player with a one-cycle new-note strobe, then waits for its note-done before advancing.
- Sits between the debounced/one-pulsed buttons, the song ROM, and the note player control.

Parameters:
- SONG_W, 2, song index width; number of songs = 2**SONG_W.
- ADDR_W, 5, note address width within a song; notes per song = 2**ADDR_W.
- NOTE_W, 6, note code width.
- DUR_W, 6, duration width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- play_button  input  1  one-cycle pulse; toggles play/pause.
- next_button  input  1  one-cycle pulse; advance to next song.
- note_done  input  1  one-cycle pulse from note player: current note finished.
- rom_data  input  NOTE_W+DUR_W  {note, duration} from song ROM; valid 1 cycle after rom_addr.
- rom_addr  output  SONG_W+ADDR_W  {song, note_addr}; combinational from registers.
- play  output  1  to note player play_enable; 1 only while playing.
- new_note  output  1  registered one-cycle strobe; note/duration valid.
- note  output  NOTE_W  latched note code.
- duration  output  DUR_W  latched duration.
- song  output  SONG_W  current song index.
- song_done  output  1  registered one-cycle pulse at end of song.
- reset_player  output  1  registered one-cycle pulse on song change.

Behaviour:
- Reset (reset==0 at clk edge):
  - state=PAUSED; song=0; note_addr=0.
  - note=0, duration=0.
  - play, new_note, song_done, reset_player = 0.
- States: PAUSED, FETCH, ROM_WAIT, CHECK, WAIT_DONE.
- PAUSED: play=0.
  - play_button -> FETCH.
  - next_button -> song advance (see below), stay PAUSED.
- FETCH: rom_addr presents {song,note_addr}; -> ROM_WAIT.
- ROM_WAIT: one cycle for ROM latency; -> CHECK.
- CHECK:
  - If rom_data duration field == 0, the song has ended:
    - Pulse song_done next cycle.
    - note_addr=0, song unchanged.
    - -> PAUSED.
  - Else:
    - Latch note/duration.
    - Pulse new_note for exactly 1 cycle, coincident with the updated note/duration.
    - -> WAIT_DONE.
- WAIT_DONE: play=1.
  - On note_done:
    - If note_addr == 2**ADDR_W-1: treat as end of song (song_done pulse, note_addr=0, -> PAUSED).
    - Else note_addr+1, -> FETCH.
- play is 1 in FETCH, ROM_WAIT, CHECK and WAIT_DONE; 0 in PAUSED. Latency from play_button in PAUSED to new_note = 4 cycles.
- play_button in any playing state -> PAUSED with note_addr held.
  - The note player timer is cleared when play drops.
  - Resume re-fetches and re-issues the same note_addr.
- next_button in any state -> PAUSED:
  - song = song+1, wrapping 2**SONG_W-1 -> 0.
  - note_addr=0.
  - reset_player pulsed 1 cycle.
  - new_note not issued.
- Simultaneous events:
  - next_button beats play_button.
  - note_done together with play_button in WAIT_DONE: note_addr advances, then PAUSED.
  - note_done outside WAIT_DONE is ignored.
- Reset mid-operation: immediate return to reset values on the next edge, regardless of state.
- All strobes are never asserted for more than 1 consecutive cycle.

Decomposition:
- Shared package (music_pkg):
  - State encodings for PAUSED/FETCH/ROM_WAIT/CHECK/WAIT_DONE.
  - Default SONG_W/ADDR_W/NOTE_W/DUR_W.
  - rom_data field slice constants (note in MSBs, duration in LSBs).
- One natural sub-module: song_addr_counter.
  - Holds song and note_addr.
  - Controls: inc_note, next_song, clr_note.
  - Flag: last_note.
- The FSM stays in song_sequencer.

Test Plan:
- Reset then play_button: rom_addr=0 during FETCH; ROM returns {note=5,dur=10} -> new_note high 1 cycle 4 cycles after button, note=5, duration=10, play=1.
- note_done at addr 3 with addr 4 ROM entry {note=9,dur=0} -> song_done 1-cycle pulse, play=0, note_addr=0, song unchanged, no new_note.
- Full song: all 32 entries non-zero duration, 32 note_done pulses -> exactly 32 new_note strobes, song_done after the 32nd, note_addr wraps to 0.
- Pause at addr 7 in WAIT_DONE, then play_button -> play drops next cycle; on resume rom_addr low bits=7 and the same note is reissued.
- next_button with song=3 (SONG_W=2) while playing -> song=0, note_addr=0, reset_player 1 cycle, play=0; next_button with play_button same cycle -> stays PAUSED.
- reset=0 asserted while in WAIT_DONE at addr 12, song 2 -> next edge all outputs 0, song=0, rom_addr=0.
